// File: rtl/or_1x32_1_pkg.sv
// Shared datapath constants for the OR-reduction building blocks.
package or_1x32_1_pkg;

  // Number of operand bits reduced by or_1x32_1.
  localparam int unsigned OR_WIDTH = 32;

  // Fan-in of one leaf OR cell.
  localparam int unsigned OR_CELL_FANIN = 4;

  // Leaf cells needed to cover OR_WIDTH operands.
  localparam int unsigned OR_L1_CELLS = OR_WIDTH / OR_CELL_FANIN;

  // Second-level cells, each combining OR_CELL_FANIN leaf outputs.
  localparam int unsigned OR_L2_CELLS = OR_L1_CELLS / OR_CELL_FANIN;

endpackage : or_1x32_1_pkg

// File: rtl/or_1x4_1.sv
// 4-input, 1-bit OR cell; the leaf of the or_1x32_1 tree.
module or_1x4_1 (
  output logic out,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3
);

  // Single gate level; a 1 on any input dominates X/Z on the others.
  assign out = a0 | a1 | a2 | a3;

endmodule : or_1x4_1

// File: rtl/or_1x32_1.sv
// 32-input, 1-bit OR reduction built as a fixed 3-level tree of OR cells,
// with an optional output register (async active-low reset).
module or_1x32_1
  import or_1x32_1_pkg::*;
#(
  parameter bit REGISTER_OUT = 1'b1
) (
  output logic out,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  input  logic r4,
  input  logic r5,
  input  logic r6,
  input  logic r7,
  input  logic r8,
  input  logic r9,
  input  logic r10,
  input  logic r11,
  input  logic r12,
  input  logic r13,
  input  logic r14,
  input  logic r15,
  input  logic r16,
  input  logic r17,
  input  logic r18,
  input  logic r19,
  input  logic r20,
  input  logic r21,
  input  logic r22,
  input  logic r23,
  input  logic r24,
  input  logic r25,
  input  logic r26,
  input  logic r27,
  input  logic r28,
  input  logic r29,
  input  logic r30,
  input  logic r31,
  input  logic clk,
  input  logic rst_n
);

  logic [OR_WIDTH-1:0]    r_vec;
  logic [OR_L1_CELLS-1:0] l1_or;
  logic [OR_L2_CELLS-1:0] l2_or;
  logic                   or_all;

  // Gather the scalar operand ports into a vector so the tree can be generated.
  assign r_vec = {r31, r30, r29, r28, r27, r26, r25, r24,
                  r23, r22, r21, r20, r19, r18, r17, r16,
                  r15, r14, r13, r12, r11, r10, r9,  r8,
                  r7,  r6,  r5,  r4,  r3,  r2,  r1,  r0};

  // Level 1: cell i covers r[4i+3:4i].
  for (genvar i = 0; i < OR_L1_CELLS; i++) begin : g_l1
    or_1x4_1 u_or_l1 (
      .out (l1_or[i]),
      .a0  (r_vec[OR_CELL_FANIN*i + 0]),
      .a1  (r_vec[OR_CELL_FANIN*i + 1]),
      .a2  (r_vec[OR_CELL_FANIN*i + 2]),
      .a3  (r_vec[OR_CELL_FANIN*i + 3])
    );
  end

  // Level 2: cell j combines leaf cells 4j..4j+3.
  for (genvar j = 0; j < OR_L2_CELLS; j++) begin : g_l2
    or_1x4_1 u_or_l2 (
      .out (l2_or[j]),
      .a0  (l1_or[OR_CELL_FANIN*j + 0]),
      .a1  (l1_or[OR_CELL_FANIN*j + 1]),
      .a2  (l1_or[OR_CELL_FANIN*j + 2]),
      .a3  (l1_or[OR_CELL_FANIN*j + 3])
    );
  end

  // Level 3: final 2-input OR of the two second-level results.
  assign or_all = l2_or[0] | l2_or[1];

  if (REGISTER_OUT) begin : g_reg_out
    logic out_q;

    // Capture the tree result each edge; reset clears it without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= 1'b0;
      end else begin
        out_q <= or_all;
      end
    end

    assign out = out_q;
  end else begin : g_comb_out
    // clk and rst_n are intentionally unused in this build.
    assign out = or_all;
  end

endmodule : or_1x32_1

// File: tb/tb_or_1x32_1.sv
// Self-checking bench for or_1x32_1: registered build checked via a scoreboard,
// combinational build checked directly alongside it.
module tb_or_1x32_1;

  logic        clk;
  logic        rst_n;
  logic [31:0] r;
  logic        out_reg;
  logic        out_comb;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        sb_q[$];

  or_1x32_1 #(.REGISTER_OUT(1'b1)) u_dut_reg (
    .out(out_reg),
    .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),
    .r4(r[4]),   .r5(r[5]),   .r6(r[6]),   .r7(r[7]),
    .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .r16(r[16]), .r17(r[17]), .r18(r[18]), .r19(r[19]),
    .r20(r[20]), .r21(r[21]), .r22(r[22]), .r23(r[23]),
    .r24(r[24]), .r25(r[25]), .r26(r[26]), .r27(r[27]),
    .r28(r[28]), .r29(r[29]), .r30(r[30]), .r31(r[31]),
    .clk(clk),
    .rst_n(rst_n)
  );

  or_1x32_1 #(.REGISTER_OUT(1'b0)) u_dut_comb (
    .out(out_comb),
    .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),
    .r4(r[4]),   .r5(r[5]),   .r6(r[6]),   .r7(r[7]),
    .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .r16(r[16]), .r17(r[17]), .r18(r[18]), .r19(r[19]),
    .r20(r[20]), .r21(r[21]), .r22(r[22]), .r23(r[23]),
    .r24(r[24]), .r25(r[25]), .r26(r[26]), .r27(r[27]),
    .r28(r[28]), .r29(r[29]), .r30(r[30]), .r31(r[31]),
    .clk(clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: any bit set.
  function automatic logic model_or(input logic [31:0] v);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 32; k++) acc = acc | v[k];
    return acc;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_check(input string tag);
    logic exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", tag, out_reg);
    end else begin
      exp = sb_q.pop_front();
      check_bit(tag, out_reg, exp);
    end
  endtask

  // Drive a pattern away from the active edge, check the comb build right away
  // and the registered build one edge later.
  task automatic apply(input string tag, input logic [31:0] v);
    @(negedge clk);
    r = v;
    sb_q.push_back(model_or(v));
    #1;
    check_bit({tag, "_comb"}, out_comb, model_or(v));
    @(posedge clk);
    #1;
    sb_check({tag, "_reg"});
  endtask

  initial begin
    logic [31:0] v;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    r        = '1;

    // Reset with all inputs high: registered out clears with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_bit("reset_async", out_reg, 1'b0);
    check_bit("reset_comb_unaffected", out_comb, 1'b1);
    @(posedge clk);
    #1;
    check_bit("reset_hold", out_reg, 1'b0);

    // Release: first edge loads or_all.
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model_or(r));
    #1;
    check_bit("release_before_edge", out_reg, 1'b0);
    @(posedge clk);
    #1;
    sb_check("release_first_edge");

    apply("all_zero", 32'h0);
    apply("r24_only", 32'h0100_0000);

    for (int i = 0; i < 32; i++) begin
      v = 32'h1 << i;
      apply($sformatf("walk%0d", i), v);
    end

    apply("back_to_zero", 32'h0);
    v = (32'h1 << 3) | (32'h1 << 10) | (32'h1 << 14) | (32'h1 << 18) |
        (32'h1 << 22) | (32'h1 << 24);
    apply("multi_bit", v);
    apply("all_ones", 32'hFFFF_FFFF);
    apply("zero_again", 32'h0);

    // Input change between edges only shows after the next edge.
    @(negedge clk);
    r[31] = 1'b1;
    #1;
    check_bit("mid_r31_no_effect", out_reg, 1'b0);
    check_bit("mid_r31_comb", out_comb, 1'b1);
    @(posedge clk);
    #1;
    check_bit("mid_r31_at_edge", out_reg, 1'b1);

    // Glitch between edges is filtered; only the value at the edge counts.
    #1 r[31] = 1'b0;
    #1;
    check_bit("glitch_low_hold", out_reg, 1'b1);
    check_bit("glitch_low_comb", out_comb, 1'b0);
    #2 r[31] = 1'b1;
    @(posedge clk);
    #1;
    check_bit("glitch_filtered", out_reg, 1'b1);

    // Mid-cycle reset while out is 1: clears before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check_bit("mid_reset_async", out_reg, 1'b0);
    check_bit("mid_reset_comb", out_comb, 1'b1);
    @(posedge clk);
    #1;
    check_bit("mid_reset_hold", out_reg, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    sb_q.push_back(model_or(r));
    @(posedge clk);
    #1;
    sb_check("mid_reset_release");

    // Reset toggling has no effect on the combinational build.
    @(negedge clk);
    r = 32'h0;
    rst_n = 1'b0;
    #1;
    check_bit("comb_zero_in_reset", out_comb, 1'b0);
    r = 32'h0100_0000;
    #1;
    check_bit("comb_r24_in_reset", out_comb, 1'b1);
    rst_n = 1'b1;
    #1;
    check_bit("comb_r24_after_reset", out_comb, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule : tb_or_1x32_1
